if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage for the MIPS pipeline, feeding the IF/ID pipeline register. It owns the word-addressed PC and issues single-outstanding requests to instruction memory. It buffers one fetched instruction with its PC+1 for the IF/ID stage. It applies stall and branch/jump/jump-register redirects, and discards stale in-flight responses after a redirect.

Parameters:
PC_W, 30, word-address width (byte address bits [31:2])
INSTR_W, 32, instruction width
RESET_PC, 30'h0000_0C00, fetch address after reset (byte 0x0000_3000)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  load-use stall from hazard unit; IF/ID does not consume this cycle
br_taken_i  input  1  taken branch resolved downstream (oldest, highest priority)
br_target_i  input  PC_W  branch target word address
jmpr_i  input  1  jr/jalr redirect
jmpr_target_i  input  PC_W  register target word address
jmp_i  input  1  j/jal redirect
jmp_target_i  input  PC_W  full jump target word address, formed by decode
imem_req_o  output  1  single-cycle request pulse
imem_addr_o  output  PC_W  request word address, valid with imem_req_o
imem_rdata_i  input  INSTR_W  instruction data
imem_valid_i  input  1  exactly one response per request, >=1 cycle after request
if_instr_o  output  INSTR_W  buffered instruction to IF/ID
if_pc_o  output  PC_W  buffered instruction address + 1
if_valid_o  output  1  buffer holds a valid instruction

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=BOOT.
  - buf_valid=0; if_instr_o=0; if_pc_o=0; if_valid_o=0; imem_req_o=0; imem_addr_o=0.
- Buffer consume rule:
  - Consume = if_valid_o && !stall_i.
  - Consumed entry clears at the next edge unless refilled that edge.
- Redirect selection: redirect = br_taken_i | jmpr_i | jmp_i.
  - Target priority: br > jmpr > jmp.
  - A redirect overrides stall_i.
  - A redirect clears buf_valid and sets pc <= target.
- States:
  - BOOT:
    - No request. Next cycle -> ISSUE.
    - imem_valid_i is ignored.
    - A redirect in BOOT only updates pc.
  - ISSUE:
    - Issue condition is (!buf_valid || consume) && !redirect.
    - When it holds: imem_req_o=1, imem_addr_o=pc, next state -> WAIT.
    - Otherwise imem_req_o=0 and the state stays ISSUE.
    - A redirect in ISSUE suppresses the request, updates pc, and stays in ISSUE.
  - WAIT:
    - imem_valid_i && !redirect: buffer <= {imem_rdata_i, pc+1}, buf_valid=1, pc <= pc+1, -> ISSUE.
    - imem_valid_i && redirect: drop the response, pc <= target, -> ISSUE.
    - !imem_valid_i && redirect: pc <= target, -> DRAIN.
  - DRAIN:
    - Wait for the stale response. On imem_valid_i, discard it -> ISSUE.
    - A further redirect in DRAIN overwrites pc; the latest redirect wins.
- Buffer occupancy: the issue rule guarantees the buffer is free when a response lands, because memory is never backpressured.
- Throughput: one instruction per 2 cycles with 1-cycle memory.
  - Latency from response to if_valid_o is 1 cycle.
- PC arithmetic: pc+1 is PC_W-bit modulo; 30'h3FFF_FFFF wraps to 0.
- imem_valid_i outside WAIT/DRAIN is ignored; this is flagged as a protocol error by an assertion.
- Outputs are registered. if_instr_o/if_pc_o hold while stall_i && if_valid_o.

Decomposition:
- Shared package if_pkg holds:
  - PC_W, INSTR_W and RESET_PC defaults.
  - The state encoding BOOT=2'd0, ISSUE=2'd1, WAIT=2'd2, DRAIN=2'd3.
  - The NOP constant 32'h0.
- Sub-module pc_next_sel: combinational redirect priority mux producing redirect and target. Reused by verification as the reference model.

Test Plan:
- Reset release, 1-cycle imem returning 32'h2001_0005 at 0xC00:
  - BOOT 1 cycle, then req addr 0xC00.
  - if_valid_o=1, if_instr_o=32'h2001_0005, if_pc_o=0xC01.
  - Next req addr 0xC01.
- Buffer valid and stall_i held 3 cycles:
  - No imem_req_o; outputs stable.
  - Req for next address is issued in the cycle stall_i drops.
- 3-cycle imem, jmp_i target 0x100 pulsed in WAIT:
  - Goes to DRAIN; stale word is discarded.
  - if_valid_o stays 0 until the word from 0x100 arrives.
  - Next req addr 0x100.
- br_taken_i (0x200), jmpr_i (0x280), jmp_i (0x300) in the same cycle: next req addr 0x200 and the buffer is cleared.
- Redirect (jmpr_i 0x40) coincident with imem_valid_i: response dropped, -> ISSUE, req addr 0x40.
- Edge cases:
  - PC at 0x3FFF_FFFF fetched: if_pc_o=0, next req addr 0.
  - rst asserted mid-WAIT: all outputs 0 immediately.
  - After release, first req addr = RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, reset PC,
// fetch FSM state encoding and the NOP word.
package if_pkg;

   localparam int PC_W    = 30;
   localparam int INSTR_W = 32;

   localparam logic [29:0] RESET_PC = 30'h0000_0C00;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if #(
   parameter int PC_W    = if_pkg::PC_W,
   parameter int INSTR_W = if_pkg::INSTR_W
);

   logic               imem_req_o;
   logic [PC_W-1:0]    imem_addr_o;
   logic [INSTR_W-1:0] imem_rdata_i;
   logic               imem_valid_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rdata_i,
      input  imem_valid_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rdata_i,
      output imem_valid_i
   );

endinterface

// File: rtl/if_fetch_unit_chk.sv
// Protocol checker for the fetch unit's instruction-memory interface.
module if_fetch_unit_chk
   import if_pkg::*;
(
   input logic       clk,
   input logic       rst,
   input logic [1:0] state,
   input logic       imem_valid
);

   // A response is only legal while a request is outstanding or being drained
   a_valid_in_window: assert property (@(posedge clk) disable iff (!rst)
      imem_valid |-> (state == ST_WAIT || state == ST_DRAIN));

endmodule

// File: rtl/pc_next_sel.sv
// Redirect priority mux: a resolved branch is oldest and wins over jr/jalr,
// which wins over j/jal.
module pc_next_sel #(
   parameter int PC_W = if_pkg::PC_W
) (
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmpr,
   input  logic [PC_W-1:0] jmpr_target,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   output logic            redirect,
   output logic [PC_W-1:0] target
);

   // Priority selection of the redirect target
   always_comb begin
      redirect = br_taken | jmpr | jmp;
      if (br_taken) begin
         target = br_target;
      end else if (jmpr) begin
         target = jmpr_target;
      end else if (jmp) begin
         target = jmp_target;
      end else begin
         target = {PC_W{1'b0}};
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, keeps one imem request in flight,
// buffers one instruction for IF/ID and discards responses made stale by redirects.
module if_fetch_unit #(
   parameter int              PC_W     = if_pkg::PC_W,
   parameter int              INSTR_W  = if_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = if_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               br_taken_i,
   input  logic [PC_W-1:0]    br_target_i,
   input  logic               jmpr_i,
   input  logic [PC_W-1:0]    jmpr_target_i,
   input  logic               jmp_i,
   input  logic [PC_W-1:0]    jmp_target_i,
   if_fetch_unit_if.master    imem,
   output logic [INSTR_W-1:0] if_instr_o,
   output logic [PC_W-1:0]    if_pc_o,
   output logic               if_valid_o
);

   import if_pkg::*;

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [PC_W-1:0]    pc_r;
   logic [PC_W-1:0]    pc_nxt_s;
   logic [PC_W-1:0]    pc_inc_s;
   logic [PC_W-1:0]    target_s;
   logic               redirect_s;
   logic               buf_valid_r;
   logic               buf_valid_nxt_s;
   logic [INSTR_W-1:0] instr_r;
   logic [PC_W-1:0]    buf_pc_r;
   logic               consume_s;
   logic               issue_s;
   logic               fill_s;

   pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
      .br_taken    (br_taken_i),
      .br_target   (br_target_i),
      .jmpr        (jmpr_i),
      .jmpr_target (jmpr_target_i),
      .jmp         (jmp_i),
      .jmp_target  (jmp_target_i),
      .redirect    (redirect_s),
      .target      (target_s)
   );

   // Modulo increment: the top word address wraps to zero
   assign pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
   assign consume_s = buf_valid_r & ~stall_i;
   // Only request when the response is guaranteed a free buffer slot
   assign issue_s   = (state_r == ST_ISSUE) & (~buf_valid_r | consume_s) & ~redirect_s;
   assign fill_s    = (state_r == ST_WAIT) & imem.imem_valid_i & ~redirect_s;

   assign imem.imem_req_o  = issue_s;
   assign imem.imem_addr_o = issue_s ? pc_r : {PC_W{1'b0}};

   // Fetch FSM next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (issue_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (imem.imem_valid_i) begin
               state_nxt_s = ST_ISSUE;
            end else if (redirect_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (imem.imem_valid_i) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // PC and buffer-occupancy next values; a redirect beats stall and refill
   always_comb begin
      pc_nxt_s        = pc_r;
      buf_valid_nxt_s = buf_valid_r;
      if (redirect_s) begin
         pc_nxt_s        = target_s;
         buf_valid_nxt_s = 1'b0;
      end else if (fill_s) begin
         pc_nxt_s        = pc_inc_s;
         buf_valid_nxt_s = 1'b1;
      end else if (consume_s) begin
         buf_valid_nxt_s = 1'b0;
      end else begin
         buf_valid_nxt_s = buf_valid_r;
      end
   end

   // State, PC and IF/ID buffer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_BOOT;
         pc_r        <= RESET_PC;
         buf_valid_r <= 1'b0;
         instr_r     <= INSTR_W'(NOP);
         buf_pc_r    <= {PC_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         buf_valid_r <= buf_valid_nxt_s;
         if (fill_s) begin
            instr_r  <= imem.imem_rdata_i;
            buf_pc_r <= pc_inc_s;
         end
      end
   end

   assign if_instr_o = instr_r;
   assign if_pc_o    = buf_pc_r;
   assign if_valid_o = buf_valid_r;

   if_fetch_unit_chk u_chk (
      .clk        (clk),
      .rst        (rst),
      .state      (state_r),
      .imem_valid (imem.imem_valid_i)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable instruction memory.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, br_taken_i, jmpr_i, jmp_i;
   logic [29:0] br_target_i, jmpr_target_i, jmp_target_i;
   logic [31:0] if_instr_o;
   logic [29:0] if_pc_o;
   logic        if_valid_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat      = 1;
   int          rem;
   logic        busy;
   logic [29:0] paddr;

   if_fetch_unit_if #(.PC_W(30), .INSTR_W(32)) imem ();

   if_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .jmpr_i        (jmpr_i),
      .jmpr_target_i (jmpr_target_i),
      .jmp_i         (jmp_i),
      .jmp_target_i  (jmp_target_i),
      .imem          (imem),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_valid_o    (if_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      if (a == 30'h0000_0C00) return 32'h2001_0005;
      return {2'b10, a};
   endfunction

   // Memory model: one response per request, lat cycles after the request
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         imem.imem_valid_i <= 1'b0;
         imem.imem_rdata_i <= 32'h0;
         busy  <= 1'b0;
         rem   <= 0;
         paddr <= 30'h0;
      end else begin
         imem.imem_valid_i <= 1'b0;
         if (imem.imem_req_o) begin
            if (lat <= 1) begin
               imem.imem_valid_i <= 1'b1;
               imem.imem_rdata_i <= mem_word(imem.imem_addr_o);
            end else begin
               busy  <= 1'b1;
               rem   <= lat - 1;
               paddr <= imem.imem_addr_o;
            end
         end else if (busy) begin
            if (rem == 1) begin
               imem.imem_valid_i <= 1'b1;
               imem.imem_rdata_i <= mem_word(paddr);
               busy <= 1'b0;
            end else begin
               rem <= rem - 1;
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %h want 0", imem.imem_req_o); end
      n_checks++; if (imem.imem_addr_o !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem.imem_addr_o); end
      n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h want 0", if_valid_o); end
      n_checks++; if (if_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_instr_o); end
      n_checks++; if (if_pc_o !== 30'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_pc_o); end
      next();
   endtask

   task automatic test_boot_fetch();
      rst = 1'b1;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL boot_no_req: got %h want 0", imem.imem_req_o); end
      next();
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req: got %h want 1", imem.imem_req_o); end
      n_checks++; if (imem.imem_addr_o !== 30'h0000_0C00) begin n_fail++; $display("FAIL first_addr: got %h want c00", imem.imem_addr_o); end
      next();
      #1;
      n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait_valid: got %h want 0", if_valid_o); end
      next();
      #1;
      n_checks++; if (if_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %h want 1", if_valid_o); end
      n_checks++; if (if_instr_o !== 32'h2001_0005) begin n_fail++; $display("FAIL fetch_instr: got %h want 20010005", if_instr_o); end
      n_checks++; if (if_pc_o !== 30'h0000_0C01) begin n_fail++; $display("FAIL fetch_pc: got %h want c01", if_pc_o); end
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0C01) begin n_fail++; $display("FAIL second_req: got %h/%h want 1/c01", imem.imem_req_o, imem.imem_addr_o); end
      next();
   endtask

   task automatic test_stall();
      next();
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) next();
         #1;
         n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %h want 0", k, imem.imem_req_o); end
         n_checks++; if (if_valid_o !== 1'b1 || if_instr_o !== mem_word(30'h0000_0C01) || if_pc_o !== 30'h0000_0C02) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got %h/%h/%h want 1/%h/c02", k, if_valid_o, if_instr_o, if_pc_o, mem_word(30'h0000_0C01));
         end
      end
      next();
      stall_i = 1'b0;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0C02) begin n_fail++; $display("FAIL unstall_req: got %h/%h want 1/c02", imem.imem_req_o, imem.imem_addr_o); end
      next();
   endtask

   task automatic test_jmp_drain();
      int   cyc;
      logic found;
      next();
      lat = 3;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0C03) begin n_fail++; $display("FAIL pre_jmp_req: got %h/%h want 1/c03", imem.imem_req_o, imem.imem_addr_o); end
      next();
      jmp_i = 1'b1; jmp_target_i = 30'h0000_0100;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL jmp_wait_req: got %h want 0", imem.imem_req_o); end
      next();
      jmp_i = 1'b0;
      #1;
      n_checks++; if (if_valid_o !== 1'b0 || imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %h/%h want 0/0", if_valid_o, imem.imem_req_o); end
      next();
      #1;
      n_checks++; if (imem.imem_valid_i !== 1'b1 || imem.imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL drain_stale: got rsp=%h req=%h valid=%h want 1/0/0", imem.imem_valid_i, imem.imem_req_o, if_valid_o);
      end
      next();
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0100) begin n_fail++; $display("FAIL jmp_req: got %h/%h want 1/100", imem.imem_req_o, imem.imem_addr_o); end
      next();
      lat = 1; stall_i = 1'b1;
      found = 1'b0; cyc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         cyc = i;
         if (if_valid_o) begin found = 1'b1; break; end
         next();
      end
      n_checks++; if (found !== 1'b1 || cyc != 3) begin n_fail++; $display("FAIL jmp_fill_time: got found=%h cyc=%0d want 1/3", found, cyc); end
      n_checks++; if (if_instr_o !== 32'h8000_0100 || if_pc_o !== 30'h0000_0101) begin n_fail++; $display("FAIL jmp_fill_data: got %h/%h want 80000100/101", if_instr_o, if_pc_o); end
      next();
   endtask

   task automatic test_multi_redirect();
      br_taken_i = 1'b1; br_target_i   = 30'h0000_0200;
      jmpr_i     = 1'b1; jmpr_target_i = 30'h0000_0280;
      jmp_i      = 1'b1; jmp_target_i  = 30'h0000_0300;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL multi_req: got %h want 0", imem.imem_req_o); end
      next();
      br_taken_i = 1'b0; jmpr_i = 1'b0; jmp_i = 1'b0; stall_i = 1'b0;
      #1;
      n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL multi_clear: got %h want 0", if_valid_o); end
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0200) begin n_fail++; $display("FAIL multi_target: got %h/%h want 1/200", imem.imem_req_o, imem.imem_addr_o); end
      next();
      next();
      #1;
      n_checks++; if (if_valid_o !== 1'b1 || if_instr_o !== 32'h8000_0200 || if_pc_o !== 30'h0000_0201) begin
         n_fail++; $display("FAIL br_fill: got %h/%h/%h want 1/80000200/201", if_valid_o, if_instr_o, if_pc_o);
      end
      next();
   endtask

   task automatic test_redirect_with_valid();
      jmpr_i = 1'b1; jmpr_target_i = 30'h0000_0040;
      #1;
      n_checks++; if (imem.imem_valid_i !== 1'b1 || imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL coinc_setup: got rsp=%h req=%h want 1/0", imem.imem_valid_i, imem.imem_req_o); end
      next();
      jmpr_i = 1'b0;
      #1;
      n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL coinc_drop: got %h want 0", if_valid_o); end
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0040) begin n_fail++; $display("FAIL coinc_req: got %h/%h want 1/40", imem.imem_req_o, imem.imem_addr_o); end
      next();
      next();
      #1;
      n_checks++; if (if_instr_o !== 32'h8000_0040 || if_pc_o !== 30'h0000_0041) begin n_fail++; $display("FAIL jmpr_fill: got %h/%h want 80000040/41", if_instr_o, if_pc_o); end
      next();
   endtask

   task automatic test_wrap();
      jmp_i = 1'b1; jmp_target_i = 30'h3FFF_FFFF;
      #1;
      next();
      jmp_i = 1'b0;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_req: got %h/%h want 1/3fffffff", imem.imem_req_o, imem.imem_addr_o); end
      next();
      next();
      lat = 3;
      #1;
      n_checks++; if (if_valid_o !== 1'b1 || if_instr_o !== 32'hBFFF_FFFF || if_pc_o !== 30'h0) begin
         n_fail++; $display("FAIL wrap_fill: got %h/%h/%h want 1/bfffffff/0", if_valid_o, if_instr_o, if_pc_o);
      end
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0) begin n_fail++; $display("FAIL wrap_next: got %h/%h want 1/0", imem.imem_req_o, imem.imem_addr_o); end
      next();
   endtask

   task automatic test_reset_mid_wait();
      rst = 1'b0;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== 30'h0) begin n_fail++; $display("FAIL mid_rst_req: got %h/%h want 0/0", imem.imem_req_o, imem.imem_addr_o); end
      n_checks++; if (if_valid_o !== 1'b0 || if_instr_o !== 32'h0 || if_pc_o !== 30'h0) begin
         n_fail++; $display("FAIL mid_rst_out: got %h/%h/%h want 0/0/0", if_valid_o, if_instr_o, if_pc_o);
      end
      next();
      rst = 1'b1;
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_boot: got %h want 0", imem.imem_req_o); end
      next();
      #1;
      n_checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 30'h0000_0C00) begin n_fail++; $display("FAIL rst_first_req: got %h/%h want 1/c00", imem.imem_req_o, imem.imem_addr_o); end
   endtask

   initial begin
      rst = 1'b0;
      stall_i = 1'b0; br_taken_i = 1'b0; jmpr_i = 1'b0; jmp_i = 1'b0;
      br_target_i = 30'h0; jmpr_target_i = 30'h0; jmp_target_i = 30'h0;
      @(posedge clk);
      #1;
      test_reset();
      test_boot_fetch();
      test_stall();
      test_jmp_drain();
      test_multi_redirect();
      test_redirect_with_valid();
      test_wrap();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
